genius_ctrl: RTL
================

GENIUS_CTRL -- requirements
Module: genius_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 4, SHALL set the clock cycles each sequence colour is lit (legal range 1..2^16-1).
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the dark cycles after each shown colour (legal range 1..2^16-1).
REQ-003 Parameter TIMEOUT_CYCLES, default 20, SHALL set the maximum idle cycles allowed between player presses (legal range 1..2^16-1).
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 start  in  1  SHALL be a single-cycle game-start pulse.
REQ-007 btn  in  4  SHALL carry player presses: single-cycle, debounced, one-hot colour.
REQ-008 rom_data  in  4  SHALL be the combinational output of the 16x4 sequence ROM at rom_addr.
REQ-009 rom_addr  out  4  SHALL be the registered sequence ROM address.
REQ-010 led  out  4  SHALL drive the colour lamps.
REQ-011 round  out  5  SHALL report the current round number, 0..16.
REQ-012 busy  out  1  SHALL be high in every state except IDLE, WIN and LOSE.
REQ-013 win  out  1  SHALL be high exactly while in state WIN.
REQ-014 lose  out  1  SHALL be high exactly while in state LOSE.

Function
REQ-015 The FSM SHALL have the states IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN and LOSE.
REQ-016 IDLE, WIN, LOSE with start=1 -> SHOW_ON next cycle; round<=1; idx<=0; all other inputs ignored.
REQ-017 SHOW_ON SHALL last exactly SHOW_CYCLES cycles, with led=rom_data (combinational) and rom_addr=idx.
REQ-018 SHOW_ON -> SHOW_OFF; SHOW_OFF SHALL last exactly GAP_CYCLES cycles with led=0000.
REQ-019 At the end of SHOW_OFF: if idx<round-1 then idx+1 and -> SHOW_ON; else idx<=0 and -> WAIT_IN.
REQ-020 WAIT_IN SHALL drive led=0000, keep rom_addr=idx, and load the timeout counter on entry.
REQ-021 WAIT_IN, btn!=0 and btn==rom_data -> correct press; timeout counter reloads.
REQ-022 On a correct press with idx<round-1, idx SHALL increment.
REQ-023 On a correct press with idx==round-1 and round<16: round+1, idx<=0, -> SHOW_OFF (GAP_CYCLES), then replay from index 0.
REQ-024 On a correct press with idx==round-1 and round==16 -> WIN.
REQ-025 WAIT_IN, btn!=0 and btn!=rom_data (including any multi-hot value) -> LOSE next cycle.
REQ-026 WAIT_IN with no press for TIMEOUT_CYCLES consecutive cycles -> LOSE.
REQ-027 btn SHALL be ignored outside WAIT_IN.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 In WIN and LOSE, round SHALL hold its final value and led=0000.
REQ-030 SHOW and GAP counters SHALL be 16-bit and down-count to 1; there is no wrap within a phase.
REQ-031 idx SHALL be 4-bit and never exceed round-1.

Reset
REQ-032 reset=0 at a clock edge SHALL force: state IDLE, idx=0, rom_addr=0000, round=0, all counters 0, led=0000, busy=0, win=0, lose=0.
REQ-033 Reset SHALL take priority over start and btn in any state, including mid-show and mid-input.
REQ-034 After reset deasserts, the block SHALL remain in IDLE until a start pulse.

Verification (defaults, ROM all 0001 unless stated)
REQ-035 start at cycle 0 -> led=0001 on cycles 1-4; led=0000 on cycles 5-6; WAIT_IN from cycle 7; round=1, busy=1.
REQ-036 Round 1, btn=0001 -> SHOW_OFF then replay of 2 colours (rom_addr 0 then 1); round=2.
REQ-037 In WAIT_IN, btn=0010 while rom_data=0001 -> lose=1 next cycle, busy=0; then start -> round=1 and replay begins.
REQ-038 In WAIT_IN, no press for 20 cycles -> lose=1; a press at cycle 19 reloads the counter and the game continues.
REQ-039 Correct play through all 16 rounds (ROM loaded with a mixed pattern) -> win=1, round=16; btn pulses during SHOW_ON have no effect.
REQ-040 reset=0 during SHOW_ON of round 3 -> next cycle: IDLE, round=0, led=0000, rom_addr=0000; start while busy is ignored.

Source files
------------

// File: rtl/genius_ctrl_if.sv
// Handshake bundle between the Genius game controller and its environment.
// Carries start/btn/rom_data towards the controller and rom_addr/led/status back.
interface genius_ctrl_if;
    logic       start;
    logic [3:0] btn;
    logic [3:0] rom_data;
    logic [3:0] rom_addr;
    logic [3:0] led;
    logic [4:0] round;
    logic       busy;
    logic       win;
    logic       lose;

    modport master (
        output start, btn, rom_data,
        input  rom_addr, led, round, busy, win, lose
    );

    modport slave (
        input  start, btn, rom_data,
        output rom_addr, led, round, busy, win, lose
    );
endinterface

// File: rtl/genius_ctrl.sv
// Genius/Simon memory game controller: shows a growing colour sequence from a
// 16x4 ROM, then checks the player's one-hot presses against it.
// Ports: clock, reset (sync, active-low), bus (slave side of genius_ctrl_if).
module genius_ctrl #(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20
) (
    input  logic          clock,
    input  logic          reset,
    genius_ctrl_if.slave  bus
);
    localparam logic [15:0] SHOW_LD = 16'(SHOW_CYCLES);
    localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES);
    localparam logic [15:0] TO_LD   = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
    } state_t;

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [4:0]  round, round_n;
    logic [15:0] cnt, cnt_n;
    // Set when the gap follows a completed round: the replay must start
    // at index 0 instead of advancing idx.
    logic        replay, replay_n;
    logic        last;

    assign last = ({1'b0, idx} == (round - 5'd1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= 4'd0;
            round  <= 5'd0;
            cnt    <= 16'd0;
            replay <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            round  <= round_n;
            cnt    <= cnt_n;
            replay <= replay_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        round_n  = round;
        cnt_n    = cnt;
        replay_n = replay;
        case (state)
            SHOW_ON: begin
                if (cnt == 16'd1) begin
                    state_n = SHOW_OFF;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            SHOW_OFF: begin
                if (cnt != 16'd1) begin
                    cnt_n = cnt - 16'd1;
                end else if (replay) begin
                    replay_n = 1'b0;
                    state_n  = SHOW_ON;
                    cnt_n    = SHOW_LD;
                end else if (!last) begin
                    idx_n   = idx + 4'd1;
                    state_n = SHOW_ON;
                    cnt_n   = SHOW_LD;
                end else begin
                    idx_n   = 4'd0;
                    state_n = WAIT_IN;
                    cnt_n   = TO_LD;
                end
            end
            WAIT_IN: begin
                if (bus.btn != 4'd0) begin
                    if (bus.btn == bus.rom_data) begin
                        cnt_n = TO_LD;
                        if (!last) begin
                            idx_n = idx + 4'd1;
                        end else if (round < 5'd16) begin
                            round_n  = round + 5'd1;
                            idx_n    = 4'd0;
                            state_n  = SHOW_OFF;
                            cnt_n    = GAP_LD;
                            replay_n = 1'b1;
                        end else begin
                            state_n = WIN;
                        end
                    end else begin
                        state_n = LOSE;
                    end
                end else if (cnt == 16'd1) begin
                    state_n = LOSE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: begin
                if (bus.start) begin
                    state_n  = SHOW_ON;
                    round_n  = 5'd1;
                    idx_n    = 4'd0;
                    cnt_n    = SHOW_LD;
                    replay_n = 1'b0;
                end
            end
        endcase
    end

    assign bus.rom_addr = idx;
    assign bus.led      = (state == SHOW_ON) ? bus.rom_data : 4'd0;
    assign bus.round    = round;
    assign bus.busy     = (state == SHOW_ON) || (state == SHOW_OFF) ||
                          (state == WAIT_IN);
    assign bus.win      = (state == WIN);
    assign bus.lose     = (state == LOSE);
endmodule
